// File: rtl/gullfaxi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gullfaxi_pkg
// Purpose  : Shared constants and types for the Gullfaxi single-input router
// Revision : 1.0 - initial release
// ============================================================================
package gullfaxi_pkg;

  localparam int DATA_W  = 8;   // payload byte width
  localparam int MAX_LEN = 16;  // bytes stored per packet
  localparam int LEN_W   = 5;   // must hold 0..MAX_LEN inclusive
  localparam int N_OUT   = 3;   // number of output ports
  localparam int ADDR_W  = $clog2(MAX_LEN);

  // Saturation limit expressed at the width of the count itself
  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  typedef logic [1:0] dest_t;

  // Header code 3 has no output behind it
  localparam dest_t DEST_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    REQ  = 2'd2,
    SEND = 2'd3
  } state_t;

endpackage : gullfaxi_pkg
`default_nettype wire

// File: rtl/gullfaxi_pkt_buffer.sv
`default_nettype none
// ============================================================================
// Module   : gullfaxi_pkt_buffer
// Purpose  : MAX_LEN x DATA_W payload store. The saturating count doubles as
//            the write pointer; reads are combinational by index.
// Revision : 1.0 - initial release
// ============================================================================
module gullfaxi_pkt_buffer
  import gullfaxi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,     // asynchronous, active-low
  input  logic              clr,       // start of a new packet
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_idx,
  output logic [DATA_W-1:0] rd_data,
  output logic [LEN_W-1:0]  count
);

  logic [DATA_W-1:0] mem [MAX_LEN];
  logic              room;

  // Bytes arriving once the store is full are accepted upstream but dropped here
  assign room    = (count != MAX_CNT);
  assign rd_data = mem[rd_idx];

  // Payload storage; contents need no reset because count gates every use
  always_ff @(posedge clk) begin
    if (wr_en && room && !clr) begin
      mem[count[ADDR_W-1:0]] <= wr_data;
    end
  end

  // Write pointer / byte count, saturating at MAX_LEN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (wr_en && room) begin
      count <= count + LEN_W'(1);
    end
  end

endmodule : gullfaxi_pkt_buffer
`default_nettype wire

// File: rtl/gullfaxi_router.sv
`default_nettype none
// ============================================================================
// Module   : gullfaxi_router
// Purpose  : Store-and-forward router, one input to three outputs. Buffers a
//            whole payload, requests the destination, then streams it out
//            with the length presented alongside the first byte.
// Revision : 1.0 - initial release
// ============================================================================
module gullfaxi_router
  import gullfaxi_pkg::*;
(
  input  logic              clk,
  input  logic              reset,      // asynchronous, active-low

  input  logic              I0_valid,
  input  logic [DATA_W-1:0] I0_data,
  input  logic              I0_end,
  output logic              I0_ready,

  output logic              O0_start,
  output logic [LEN_W-1:0]  O0_length,
  output logic [DATA_W-1:0] O0_data,
  output logic              O0_end,
  output logic              O0_req,
  input  logic              O0_grant,

  output logic              O1_start,
  output logic [LEN_W-1:0]  O1_length,
  output logic [DATA_W-1:0] O1_data,
  output logic              O1_end,
  output logic              O1_req,
  input  logic              O1_grant,

  output logic              O2_start,
  output logic [LEN_W-1:0]  O2_length,
  output logic [DATA_W-1:0] O2_data,
  output logic              O2_end,
  output logic              O2_req,
  input  logic              O2_grant
);

  state_t            state_q, state_d;
  dest_t             dest_q, dest_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              ready_q, ready_d;

  // Per-port registered outputs; only the selected port ever goes non-zero
  logic [N_OUT-1:0]  req_q, req_d;
  logic [N_OUT-1:0]  start_q, start_d;
  logic [N_OUT-1:0]  end_q, end_d;
  logic [DATA_W-1:0] data_q [N_OUT];
  logic [DATA_W-1:0] data_d [N_OUT];
  logic [LEN_W-1:0]  length_q [N_OUT];
  logic [LEN_W-1:0]  length_d [N_OUT];

  logic [N_OUT-1:0]  grant_vec;
  logic              accept;
  logic              buf_clr;
  logic              buf_wr;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_data;
  logic [LEN_W-1:0]  count;

  assign grant_vec = {O2_grant, O1_grant, O0_grant};
  assign accept    = I0_valid & ready_q;
  // REQ reads byte 0 so it can be registered on the grant edge
  assign rd_idx    = (state_q == SEND) ? idx_q[ADDR_W-1:0] : '0;

  gullfaxi_pkt_buffer u_buf (
    .clk     (clk),
    .reset   (reset),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (I0_data),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .count   (count)
  );

  // Next-state and next-output logic for the receive/request/send sequence
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    idx_d   = idx_q;
    req_d   = req_q;
    start_d = '0;
    end_d   = '0;
    for (int i = 0; i < N_OUT; i++) begin
      data_d[i]   = '0;
      length_d[i] = '0;
    end
    buf_clr = 1'b0;
    buf_wr  = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dest_d  = I0_data[1:0];
          buf_clr = 1'b1;
          // A header carrying the end flag is an empty packet: drop it
          if (!I0_end) state_d = RECV;
        end
      end

      RECV: begin
        if (accept) begin
          buf_wr = 1'b1;
          if (I0_end) begin
            if (dest_q == DEST_INVALID) begin
              state_d = IDLE;
            end else begin
              state_d        = REQ;
              req_d[dest_q]  = 1'b1;
            end
          end
        end
      end

      REQ: begin
        if (grant_vec[dest_q]) begin
          state_d          = SEND;
          start_d[dest_q]  = 1'b1;
          length_d[dest_q] = count;
          data_d[dest_q]   = rd_data;
          end_d[dest_q]    = (count == LEN_W'(1));
          idx_d            = LEN_W'(1);
        end
      end

      SEND: begin
        // Grant is not consulted here: a started transfer always completes
        if (end_q[dest_q]) begin
          state_d = IDLE;
          req_d   = '0;
        end else begin
          data_d[dest_q] = rd_data;
          end_d[dest_q]  = (idx_q == count - LEN_W'(1));
          idx_d          = idx_q + LEN_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE) || (state_d == RECV);
  end

  // State and output registers; reset clears every output including ready
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      dest_q  <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
      req_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      for (int i = 0; i < N_OUT; i++) begin
        data_q[i]   <= '0;
        length_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      dest_q  <= dest_d;
      idx_q   <= idx_d;
      ready_q <= ready_d;
      req_q   <= req_d;
      start_q <= start_d;
      end_q   <= end_d;
      for (int i = 0; i < N_OUT; i++) begin
        data_q[i]   <= data_d[i];
        length_q[i] <= length_d[i];
      end
    end
  end

  assign I0_ready  = ready_q;

  assign O0_start  = start_q[0];
  assign O0_length = length_q[0];
  assign O0_data   = data_q[0];
  assign O0_end    = end_q[0];
  assign O0_req    = req_q[0];

  assign O1_start  = start_q[1];
  assign O1_length = length_q[1];
  assign O1_data   = data_q[1];
  assign O1_end    = end_q[1];
  assign O1_req    = req_q[1];

  assign O2_start  = start_q[2];
  assign O2_length = length_q[2];
  assign O2_data   = data_q[2];
  assign O2_end    = end_q[2];
  assign O2_req    = req_q[2];

endmodule : gullfaxi_router
`default_nettype wire

// File: tb/tb_gullfaxi_router.sv
`default_nettype none
// ============================================================================
// Module   : tb_gullfaxi_router
// Purpose  : Directed self-checking bench for gullfaxi_router
// Revision : 1.0 - initial release
// ============================================================================
module tb_gullfaxi_router;

  logic       clk;
  logic       reset;
  logic       I0_valid;
  logic [7:0] I0_data;
  logic       I0_end;
  wire        I0_ready;
  logic [2:0] grant;

  wire [2:0] ostart;
  wire [2:0] oend;
  wire [2:0] oreq;
  wire [7:0] odata [3];
  wire [4:0] olen  [3];

  int checks   = 0;
  int failures = 0;

  gullfaxi_router dut (
    .clk       (clk),
    .reset     (reset),
    .I0_valid  (I0_valid),
    .I0_data   (I0_data),
    .I0_end    (I0_end),
    .I0_ready  (I0_ready),
    .O0_start  (ostart[0]),
    .O0_length (olen[0]),
    .O0_data   (odata[0]),
    .O0_end    (oend[0]),
    .O0_req    (oreq[0]),
    .O0_grant  (grant[0]),
    .O1_start  (ostart[1]),
    .O1_length (olen[1]),
    .O1_data   (odata[1]),
    .O1_end    (oend[1]),
    .O1_req    (oreq[1]),
    .O1_grant  (grant[1]),
    .O2_start  (ostart[2]),
    .O2_length (olen[2]),
    .O2_data   (odata[2]),
    .O2_end    (oend[2]),
    .O2_req    (oreq[2]),
    .O2_grant  (grant[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: every wait below is a fixed cycle count, this only guards hangs
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare all three ports: port p gets the given values, the others zero
  task automatic check_port(input int p, input logic st, input logic [4:0] len,
                            input logic [7:0] d, input logic e, input logic rq);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("O%0d_start", i),  ostart[i], (i == p) ? st  : 1'b0);
      check($sformatf("O%0d_length", i), olen[i],   (i == p) ? len : 5'd0);
      check($sformatf("O%0d_data", i),   odata[i],  (i == p) ? d   : 8'd0);
      check($sformatf("O%0d_end", i),    oend[i],   (i == p) ? e   : 1'b0);
      check($sformatf("O%0d_req", i),    oreq[i],   (i == p) ? rq  : 1'b0);
    end
  endtask

  // Present one byte at a negedge; the following posedge takes it
  task automatic push(input logic [7:0] d, input logic e);
    check("ready_before_push", I0_ready, 1'b1);
    I0_valid = 1'b1;
    I0_data  = d;
    I0_end   = e;
    @(negedge clk);
    I0_valid = 1'b0;
    I0_end   = 1'b0;
  endtask

  // Hold REQ for w cycles, then pulse grant for one sampling edge
  task automatic grant_after(input int p, input int w);
    for (int k = 0; k < w; k++) begin
      check_port(p, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1);
      check("ready_in_req", I0_ready, 1'b0);
      @(negedge clk);
    end
    check_port(p, 1'b0, 5'd0, 8'd0, 1'b0, 1'b1);
    grant[p] = 1'b1;
    @(negedge clk);
    grant[p] = 1'b0;
  endtask

  // Expect an n-byte transfer on port p with data base, base+1, ...
  task automatic expect_transfer(input int p, input int n, input logic [7:0] base);
    for (int k = 0; k < n; k++) begin
      check_port(p, k == 0, (k == 0) ? 5'(n) : 5'd0, base + 8'(k), k == n - 1, 1'b1);
      check("ready_in_send", I0_ready, 1'b0);
      @(negedge clk);
    end
    check_port(p, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
    check("ready_after_send", I0_ready, 1'b1);
  endtask

  initial begin
    reset    = 1'b0;
    I0_valid = 1'b0;
    I0_data  = 8'd0;
    I0_end   = 1'b0;
    grant    = 3'b000;
    repeat (3) @(negedge clk);
    check("ready_in_reset", I0_ready, 1'b0);
    check_port(0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", I0_ready, 1'b1);

    // 1: three bytes to O1, grant two cycles after req
    push(8'h01, 1'b0);
    push(8'hA0, 1'b0);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b1);
    grant_after(1, 2);
    expect_transfer(1, 3, 8'hA0);

    // 2: single byte to O2, start and end together
    push(8'h02, 1'b0);
    push(8'h5C, 1'b1);
    grant_after(2, 0);
    expect_transfer(2, 1, 8'h5C);

    // 3: empty packet, then a packet to the invalid destination
    push(8'h00, 1'b1);
    check_port(0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
    push(8'h03, 1'b0);
    push(8'h11, 1'b0);
    push(8'h12, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check_port(0, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
      check("ready_after_drop", I0_ready, 1'b1);
      @(negedge clk);
    end

    // 4: 20 payload bytes, only the first 16 are kept
    push(8'h00, 1'b0);
    for (int k = 0; k < 20; k++) push(8'(k), k == 19);
    grant_after(0, 1);
    expect_transfer(0, 16, 8'h00);

    // 5: input keeps offering bytes while the grant is withheld
    push(8'h01, 1'b0);
    for (int k = 0; k < 4; k++) push(8'h31 + 8'(k), k == 3);
    I0_valid = 1'b1;
    I0_data  = 8'hEE;
    for (int k = 0; k < 10; k++) begin
      check("ready_blocked", I0_ready, 1'b0);
      check("O1_req_held", oreq[1], 1'b1);
      @(negedge clk);
    end
    I0_valid = 1'b0;
    grant_after(1, 0);
    expect_transfer(1, 4, 8'h31);

    // 6: reset after two of four bytes, then a fresh packet
    push(8'h02, 1'b0);
    for (int k = 0; k < 4; k++) push(8'h41 + 8'(k), k == 3);
    grant_after(2, 0);
    check_port(2, 1'b1, 5'd4, 8'h41, 1'b0, 1'b1);
    @(negedge clk);
    check_port(2, 1'b0, 5'd0, 8'h42, 1'b0, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_port(2, 1'b0, 5'd0, 8'd0, 1'b0, 1'b0);
    check("ready_mid_reset", I0_ready, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_rerelease", I0_ready, 1'b1);
    push(8'h00, 1'b0);
    push(8'h77, 1'b0);
    push(8'h78, 1'b1);
    grant_after(0, 1);
    expect_transfer(0, 2, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_gullfaxi_router
`default_nettype wire

// File: doc/gullfaxi_router.md
Name: gullfaxi_router

Overview:
- Single-input, three-output packet router for the Gullfaxi fabric.
- A packet arrives on input port I0 as a header byte followed by payload bytes. The router buffers the whole payload, then requests the destination output.
- Once the output grants, the router sends the payload with an up-front length.
- One packet is in flight at a time (store-and-forward, single buffer).

Parameters:
DATA_W, 8, width of I0_data and Ox_data
MAX_LEN, 16, maximum stored payload bytes per packet
LEN_W, 5, width of Ox_length (holds 0..MAX_LEN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
I0_valid  in  1  input byte valid
I0_data  in  DATA_W  input byte (header or payload)
I0_end  in  1  qualifies last byte of packet (only when I0_valid)
I0_ready  out  1  router accepts input byte this cycle
On<_start  out  1  (n=0,1,2) first-byte strobe of output transfer
On_length  out  LEN_W  payload byte count, valid while On_start=1
On_data  out  DATA_W  output payload byte
On_end  out  1  last output byte strobe
On_req  out  1  request ownership of output n
On_grant  in  1  arbiter grant for output n

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, including I0_ready.
  - Buffer count is cleared and the FSM enters IDLE.
  - Reset mid-packet discards the packet; any On_req drops immediately.
- Input handshake: a byte transfers when I0_valid & I0_ready on a rising edge.
  - I0_ready=1 in IDLE and RECV, 0 otherwise.
  - I0_end without I0_valid is ignored.
- IDLE:
  - The accepted byte is the header; dest = header[1:0]; the rest of the header is ignored.
  - If I0_end=1 with the header (empty packet), discard it and stay in IDLE.
  - Otherwise go to RECV.
- RECV:
  - Each accepted byte is written at buffer[count] and count increments.
  - Bytes beyond MAX_LEN are accepted but discarded; count saturates at MAX_LEN.
  - On an accepted byte with I0_end=1:
    - dest=3 (invalid): drop the packet and go to IDLE.
    - otherwise go to REQ.
- REQ:
  - On_req=1 for n=dest only, registered; it rises the cycle after the end byte.
  - Wait indefinitely for On_grant[dest]. Grants on other outputs are ignored.
  - When grant is sampled 1, go to SEND.
- SEND:
  - One byte per cycle, starting the cycle after grant is sampled. Outputs are registered.
  - Cycle 0: On_start=1, On_length=count, On_data=buffer[0].
  - Cycle k: On_data=buffer[k].
  - Cycle count-1: On_end=1. When count=1, start and end assert in the same cycle.
  - On_req stays 1 through the On_end cycle, then drops.
  - Grant deassertion during SEND is ignored; the transfer always completes.
  - After the On_end cycle, go to IDLE; I0_ready=1 in the following cycle.
- Outputs for non-selected ports stay 0. On_data/On_length are 0 when not transferring.
- Latency:
  - End byte accepted at edge t: req visible after t.
  - Grant sampled at edge g: start visible after g.
  - Packet occupies output for exactly count cycles.

Decomposition:
- Package gullfaxi_pkg holds:
  - DATA_W, MAX_LEN, LEN_W.
  - State enum {IDLE, RECV, REQ, SEND}.
  - Port count constant N_OUT=3.
  - Typedef for a dest index (2 bits).
- One sub-module, gullfaxi_pkt_buffer: MAX_LEN x DATA_W register file with a write pointer, saturating count, and read index.
- Top contains the FSM and the output demux.

Test Plan:
1. Reset then header 0x01 + payload 0xA0,0xA1,0xA2 (end on 0xA2); grant O1 two cycles after O1_req.
   -> O1_start with length=3, data A0,A1,A2 on consecutive cycles, O1_end with A2; O0/O2 stay 0.
2. Header 0x02 + single byte 0x5C with end.
   -> O2_req; after grant, start=end=1 same cycle, length=1, data 0x5C.
3. Header 0x00 with end, then header 0x03 + two bytes.
   -> no req on any output; I0_ready stays 1; both packets dropped.
4. Header 0x00 + 20 bytes 0..19.
   -> O0 length=16, data 0..15, end on 15; bytes 16..19 discarded.
5. Header 0x01 + 4 bytes; hold O1_grant low 10 cycles while driving I0_valid.
   -> I0_ready=0 throughout, O1_req held; after grant, full 4-byte transfer.
6. Assert reset mid-SEND after 2 of 4 bytes.
   -> all outputs 0 immediately; after release, I0_ready=1 and a fresh packet routes correctly.
